// File: rtl/pipe5_types_pkg.sv
// Shared types for the pipe5 hazard controller: register selects, bypass codes,
// FSM encodings and the per-latch control vector.
package pipe5_types_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned RSEL_W = $clog2(NREGS);
    localparam int unsigned XLEN   = 32;

    typedef logic [RSEL_W-1:0] rsel_t;
    typedef logic [XLEN-1:0]   xword_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_M    = 2'b01,
        FWD_W    = 2'b10
    } bypass_t;

    typedef logic [1:0] hazard_state_t;
    localparam hazard_state_t ST_IDLE          = 2'b00;
    localparam hazard_state_t ST_TRAP_DRAIN    = 2'b01;
    localparam hazard_state_t ST_TRAP_REDIRECT = 2'b10;
    localparam hazard_state_t ST_HALTED        = 2'b11;

    // One bit per pipeline latch, fetch/decode down to memory/writeback
    typedef struct packed {
        logic fd;
        logic dx;
        logic xm;
        logic mw;
    } latch_vec_t;

    localparam latch_vec_t LV_NONE   = latch_vec_t'(4'b0000);
    localparam latch_vec_t LV_ALL    = latch_vec_t'(4'b1111);
    localparam latch_vec_t LV_FRONT3 = latch_vec_t'(4'b1110);
    localparam latch_vec_t LV_FRONT2 = latch_vec_t'(4'b1100);

    // x0 is hardwired, so a match on it never creates a dependency
    function automatic logic reg_match(rsel_t rs, rsel_t rd);
        return (rs == rd) && (rs != '0);
    endfunction

endpackage

// File: rtl/pipe5_hazard_controller_if.sv
// Hazard/forwarding interface between the pipe5 datapath (master) and the
// hazard controller (slave).
interface pipe5_hazard_controller_if;
    import pipe5_types_pkg::*;

    // Stage status
    logic    f_busy;
    logic    x_busy;
    logic    m_busy;
    logic    fence_stall;
    logic    x_dren;
    logic    mispredict;
    logic    halt;
    logic    ret;

    // M-stage exceptions
    logic    fault_insn;
    logic    mal_insn;
    logic    illegal_insn;
    logic    fault_ld;
    logic    mal_ld;
    logic    fault_st;
    logic    mal_st;
    logic    breakpoint;
    logic    env_m;
    xword_t  epc_m;
    xword_t  badaddr_m;
    xword_t  priv_target;

    // Register indices per stage
    rsel_t   rs1_d;
    rsel_t   rs2_d;
    rsel_t   rs1_x;
    rsel_t   rs2_x;
    rsel_t   rd_x;
    rsel_t   rd_m;
    rsel_t   rd_w;
    logic    regwen_m;
    logic    regwen_w;

    // Controls back to the pipeline
    logic    pc_en;
    logic    npc_sel;
    logic    iren;
    logic    fd_stall;
    logic    dx_stall;
    logic    xm_stall;
    logic    mw_stall;
    logic    fd_flush;
    logic    dx_flush;
    logic    xm_flush;
    logic    mw_flush;
    xword_t  priv_pc;
    logic    insert_priv_pc;
    xword_t  epc;
    xword_t  badaddr;
    bypass_t bypass_a;
    bypass_t bypass_b;
    bypass_t bypass_rs1;
    bypass_t bypass_rs2;

    modport master (
        output f_busy, x_busy, m_busy, fence_stall, x_dren, mispredict, halt, ret,
        output fault_insn, mal_insn, illegal_insn, fault_ld, mal_ld, fault_st, mal_st,
        output breakpoint, env_m, epc_m, badaddr_m, priv_target,
        output rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w, regwen_m, regwen_w,
        input  pc_en, npc_sel, iren,
        input  fd_stall, dx_stall, xm_stall, mw_stall,
        input  fd_flush, dx_flush, xm_flush, mw_flush,
        input  priv_pc, insert_priv_pc, epc, badaddr,
        input  bypass_a, bypass_b, bypass_rs1, bypass_rs2
    );

    modport slave (
        input  f_busy, x_busy, m_busy, fence_stall, x_dren, mispredict, halt, ret,
        input  fault_insn, mal_insn, illegal_insn, fault_ld, mal_ld, fault_st, mal_st,
        input  breakpoint, env_m, epc_m, badaddr_m, priv_target,
        input  rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w, regwen_m, regwen_w,
        output pc_en, npc_sel, iren,
        output fd_stall, dx_stall, xm_stall, mw_stall,
        output fd_flush, dx_flush, xm_flush, mw_flush,
        output priv_pc, insert_priv_pc, epc, badaddr,
        output bypass_a, bypass_b, bypass_rs1, bypass_rs2
    );

endinterface

// File: rtl/pipe5_bypass_select.sv
// Forwarding select for one X-stage source operand: youngest producer (M) wins over W.
module pipe5_bypass_select
    import pipe5_types_pkg::*;
(
    input  rsel_t   rs_i,
    input  rsel_t   rd_m_i,
    input  logic    regwen_m_i,
    input  rsel_t   rd_w_i,
    input  logic    regwen_w_i,
    output bypass_t sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (regwen_m_i && reg_match(rs_i, rd_m_i)) begin
            sel_o = FWD_M;
        end else if (regwen_w_i && reg_match(rs_i, rd_w_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipe5_hazard_controller.sv
// pipe5 hazard controller: trap/return sequencer, sticky halt, stall/flush priority and
// operand bypass. Build option PIPE5_FWD_EN enables forwarding; without it RAW hazards stall.
module pipe5_hazard_controller
    import pipe5_types_pkg::*;
#(
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    pipe5_hazard_controller_if.slave  hz
);

    localparam int unsigned CNT_W = $clog2(DRAIN_MAX + 1);

    hazard_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    xword_t priv_pc_q, priv_pc_d;
    xword_t epc_q, epc_d;
    xword_t badaddr_q, badaddr_d;

    logic exc_c, trap_c, load_use_c, raw_c;
    logic pc_en_c, npc_sel_c, iren_c, insert_c;
    latch_vec_t stall_raw, stall_c, flush_c;
    bypass_t sel_rs1, sel_rs2;

    assign exc_c = hz.fault_insn | hz.mal_insn | hz.illegal_insn |
                   hz.fault_ld   | hz.mal_ld   | hz.fault_st     |
                   hz.mal_st     | hz.breakpoint | hz.env_m;
    assign trap_c = exc_c | hz.ret;

    assign load_use_c = hz.x_dren &
                        (reg_match(hz.rs1_d, hz.rd_x) | reg_match(hz.rs2_d, hz.rd_x));

    pipe5_bypass_select u_bypass_rs1 (
        .rs_i       (hz.rs1_x),
        .rd_m_i     (hz.rd_m),
        .regwen_m_i (hz.regwen_m),
        .rd_w_i     (hz.rd_w),
        .regwen_w_i (hz.regwen_w),
        .sel_o      (sel_rs1)
    );

    pipe5_bypass_select u_bypass_rs2 (
        .rs_i       (hz.rs2_x),
        .rd_m_i     (hz.rd_m),
        .regwen_m_i (hz.regwen_m),
        .rd_w_i     (hz.rd_w),
        .regwen_w_i (hz.regwen_w),
        .sel_o      (sel_rs2)
    );

`ifdef PIPE5_FWD_EN
    assign raw_c         = 1'b0;
    assign hz.bypass_rs1 = sel_rs1;
    assign hz.bypass_rs2 = sel_rs2;
`else
    // Without forwarding, any operand that would have been bypassed must wait in X
    assign raw_c         = (sel_rs1 != FWD_NONE) | (sel_rs2 != FWD_NONE);
    assign hz.bypass_rs1 = FWD_NONE;
    assign hz.bypass_rs2 = FWD_NONE;
`endif
    assign hz.bypass_a = hz.bypass_rs1;
    assign hz.bypass_b = hz.bypass_rs2;

    assign cnt_next = CNT_W'(cnt_q + 1'b1);

    // Next state and pipeline controls
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        priv_pc_d = priv_pc_q;
        epc_d     = epc_q;
        badaddr_d = badaddr_q;
        pc_en_c   = 1'b0;
        npc_sel_c = 1'b0;
        iren_c    = 1'b0;
        insert_c  = 1'b0;
        stall_raw = LV_NONE;
        flush_c   = LV_NONE;

        case (state_q)
            ST_IDLE: begin
                pc_en_c = 1'b1;
                iren_c  = 1'b1;
                if (trap_c) begin
                    state_d = ST_TRAP_DRAIN;
                    cnt_d   = '0;
                    pc_en_c = 1'b0;
                    flush_c = LV_FRONT3;
                    if (exc_c) begin
                        epc_d     = hz.epc_m;
                        badaddr_d = hz.badaddr_m;
                    end
                end else if (hz.halt) begin
                    state_d   = ST_HALTED;
                    pc_en_c   = 1'b0;
                    iren_c    = 1'b0;
                    stall_raw = LV_ALL;
                end else if (hz.mispredict) begin
                    npc_sel_c = 1'b1;
                    flush_c   = LV_FRONT3;
                end else if (hz.m_busy || hz.fence_stall) begin
                    pc_en_c    = 1'b0;
                    stall_raw  = LV_FRONT3;
                    flush_c.mw = 1'b1;
                end else if (hz.x_busy || raw_c) begin
                    pc_en_c    = 1'b0;
                    stall_raw  = LV_FRONT2;
                    flush_c.xm = 1'b1;
                end else if (load_use_c) begin
                    pc_en_c      = 1'b0;
                    stall_raw.fd = 1'b1;
                    flush_c.dx   = 1'b1;
                end else if (hz.f_busy) begin
                    pc_en_c    = 1'b0;
                    flush_c.fd = 1'b1;
                end
            end

            ST_TRAP_DRAIN: begin
                // Hold the M instruction while it finishes; younger work is discarded
                iren_c       = 1'b1;
                flush_c      = LV_FRONT3;
                stall_raw.mw = hz.m_busy;
                cnt_d        = cnt_next;
                if (!hz.m_busy || (cnt_next == CNT_W'(DRAIN_MAX))) begin
                    state_d   = ST_TRAP_REDIRECT;
                    priv_pc_d = hz.priv_target;
                end
            end

            ST_TRAP_REDIRECT: begin
                iren_c     = 1'b1;
                pc_en_c    = 1'b1;
                insert_c   = 1'b1;
                flush_c.fd = 1'b1;
                state_d    = ST_IDLE;
            end

            ST_HALTED: begin
                stall_raw = LV_ALL;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst) begin
            pc_en_c   = 1'b0;
            npc_sel_c = 1'b0;
            iren_c    = 1'b0;
            insert_c  = 1'b0;
            stall_raw = LV_NONE;
            flush_c   = LV_NONE;
        end
    end

    // A latch being bubbled cannot also be held
    assign stall_c = latch_vec_t'(stall_raw & ~flush_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            priv_pc_q <= '0;
            epc_q     <= '0;
            badaddr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            priv_pc_q <= priv_pc_d;
            epc_q     <= epc_d;
            badaddr_q <= badaddr_d;
        end
    end

    assign hz.pc_en          = pc_en_c;
    assign hz.npc_sel        = npc_sel_c;
    assign hz.iren           = iren_c;
    assign hz.insert_priv_pc = insert_c;
    assign hz.fd_stall       = stall_c.fd;
    assign hz.dx_stall       = stall_c.dx;
    assign hz.xm_stall       = stall_c.xm;
    assign hz.mw_stall       = stall_c.mw;
    assign hz.fd_flush       = flush_c.fd;
    assign hz.dx_flush       = flush_c.dx;
    assign hz.xm_flush       = flush_c.xm;
    assign hz.mw_flush       = flush_c.mw;
    assign hz.priv_pc        = priv_pc_q;
    assign hz.epc            = epc_q;
    assign hz.badaddr        = badaddr_q;

endmodule

// File: tb/tb_pipe5_hazard_controller.sv
// Scoreboard bench for pipe5_hazard_controller; honours PIPE5_FWD_EN like the design.
module tb_pipe5_hazard_controller;
    import pipe5_types_pkg::*;

`ifdef PIPE5_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [1:0] BN = 2'b00;
    localparam logic [1:0] BM = 2'b01;
    localparam logic [1:0] BW = 2'b10;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [11:0] q_ctl[$];
    logic [7:0]  q_byp[$];
    string       q_tag[$];

    pipe5_hazard_controller_if hz ();

    pipe5_hazard_controller #(.DRAIN_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ctl(input logic pe, input logic ns, input logic ir,
                                        input logic ins, input logic [3:0] st,
                                        input logic [3:0] fl);
        return {pe, ns, ir, ins, st, fl};
    endfunction

    function automatic logic [7:0] byp(input logic [1:0] a, input logic [1:0] b);
        return {a, b, a, b};
    endfunction

    // Push expectation for the current inputs, then compare at the falling edge
    task automatic cycle(input string tag, input logic [11:0] exp_ctl, input logic [7:0] exp_byp);
        logic [11:0] o_ctl;
        logic [7:0]  o_byp;
        logic [11:0] e_ctl;
        logic [7:0]  e_byp;
        string       e_tag;
        q_ctl.push_back(exp_ctl);
        q_byp.push_back(exp_byp);
        q_tag.push_back(tag);
        @(negedge clk);
        o_ctl = {hz.pc_en, hz.npc_sel, hz.iren, hz.insert_priv_pc,
                 hz.fd_stall, hz.dx_stall, hz.xm_stall, hz.mw_stall,
                 hz.fd_flush, hz.dx_flush, hz.xm_flush, hz.mw_flush};
        o_byp = {hz.bypass_a, hz.bypass_b, hz.bypass_rs1, hz.bypass_rs2};
        e_ctl = q_ctl.pop_front();
        e_byp = q_byp.pop_front();
        e_tag = q_tag.pop_front();
        chk({e_tag, "/ctl"}, 32'(o_ctl), 32'(e_ctl));
        chk({e_tag, "/byp"}, 32'(o_byp), 32'(e_byp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        hz.f_busy = 0; hz.x_busy = 0; hz.m_busy = 0; hz.fence_stall = 0;
        hz.x_dren = 0; hz.mispredict = 0; hz.halt = 0; hz.ret = 0;
        hz.fault_insn = 0; hz.mal_insn = 0; hz.illegal_insn = 0; hz.fault_ld = 0;
        hz.mal_ld = 0; hz.fault_st = 0; hz.mal_st = 0; hz.breakpoint = 0; hz.env_m = 0;
        hz.epc_m = '0; hz.badaddr_m = '0;
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_x = '0; hz.rs2_x = '0;
        hz.rd_x = '0; hz.rd_m = '0; hz.rd_w = '0; hz.regwen_m = 0; hz.regwen_w = 0;
    endtask

    logic [11:0] RUN, RAWST, TRAP0, DRB, DRI, REDIR, HALTD;

    initial begin
        n_vec = 0;
        n_err = 0;
        RUN   = ctl(1, 0, 1, 0, 4'b0000, 4'b0000);
        RAWST = ctl(0, 0, 1, 0, 4'b1100, 4'b0010);
        TRAP0 = ctl(0, 0, 1, 0, 4'b0000, 4'b1110);
        DRB   = ctl(0, 0, 1, 0, 4'b0001, 4'b1110);
        DRI   = ctl(0, 0, 1, 0, 4'b0000, 4'b1110);
        REDIR = ctl(1, 0, 1, 1, 4'b0000, 4'b1000);
        HALTD = ctl(0, 0, 0, 0, 4'b1111, 4'b0000);
        rst = 1'b1;
        idle_in();
        hz.priv_target = 32'h0;

        cycle("reset", 12'h000, 8'h00);
        chk("reset/priv_pc", hz.priv_pc, 32'h0);
        chk("reset/epc", hz.epc, 32'h0);
        rst = 1'b0;
        cycle("run", RUN, 8'h00);

        // load-use on x5, then x0 destination must not stall
        hz.x_dren = 1; hz.rd_x = 5'd5; hz.rs1_d = 5'd5;
        cycle("load_use", ctl(0, 0, 1, 0, 4'b1000, 4'b0100), 8'h00);
        hz.rs1_d = 5'd1; hz.rs2_d = 5'd5;
        cycle("load_use_rs2", ctl(0, 0, 1, 0, 4'b1000, 4'b0100), 8'h00);
        hz.rd_x = 5'd0; hz.rs1_d = 5'd0; hz.rs2_d = 5'd0;
        cycle("load_x0", RUN, 8'h00);
        idle_in();
        cycle("load_clear", RUN, 8'h00);

        hz.f_busy = 1;
        cycle("f_busy", ctl(0, 0, 1, 0, 4'b0000, 4'b1000), 8'h00);
        hz.x_busy = 1;
        cycle("x_over_f", ctl(0, 0, 1, 0, 4'b1100, 4'b0010), 8'h00);
        hz.m_busy = 1; hz.x_dren = 1; hz.rd_x = 5'd9; hz.rs2_d = 5'd9;
        cycle("m_over_all", ctl(0, 0, 1, 0, 4'b1110, 4'b0001), 8'h00);
        idle_in(); hz.fence_stall = 1;
        cycle("fence", ctl(0, 0, 1, 0, 4'b1110, 4'b0001), 8'h00);
        idle_in(); hz.mispredict = 1; hz.m_busy = 1;
        cycle("mispredict", ctl(1, 1, 1, 0, 4'b0000, 4'b1110), 8'h00);
        idle_in();

        // bypass / RAW
        hz.rd_m = 5'd3; hz.rd_w = 5'd3; hz.regwen_m = 1; hz.regwen_w = 1; hz.rs1_x = 5'd3;
        cycle("byp_m_over_w", FWD ? RUN : RAWST, FWD ? byp(BM, BN) : 8'h00);
        hz.rs1_x = 5'd0;
        cycle("byp_x0", RUN, 8'h00);
        hz.rd_w = 5'd7; hz.rs1_x = 5'd7; hz.rs2_x = 5'd3;
        cycle("byp_w_m", FWD ? RUN : RAWST, FWD ? byp(BW, BM) : 8'h00);
        hz.regwen_m = 0; hz.rd_m = 5'd7; hz.rs1_x = 5'd0; hz.rs2_x = 5'd7;
        cycle("byp_wen_m_off", FWD ? RUN : RAWST, FWD ? byp(BN, BW) : 8'h00);
        hz.regwen_w = 0;
        cycle("byp_no_wen", RUN, 8'h00);
        idle_in(); hz.rd_m = 5'd12; hz.regwen_m = 1; hz.rs2_x = 5'd12;
        cycle("raw_rs2_m", FWD ? RUN : RAWST, FWD ? byp(BN, BM) : 8'h00);
        idle_in();
        cycle("raw_clear", RUN, 8'h00);

        // mal_ld trap with M busy for two cycles
        hz.mal_ld = 1; hz.epc_m = 32'h100; hz.badaddr_m = 32'hBAD0; hz.m_busy = 1;
        hz.priv_target = 32'h8000_0040;
        cycle("trap_entry", TRAP0, 8'h00);
        hz.mal_ld = 0; hz.epc_m = 32'h0; hz.badaddr_m = 32'h0;
        cycle("drain_busy", DRB, 8'h00);
        hz.m_busy = 0;
        cycle("drain_done", DRI, 8'h00);
        cycle("redirect", REDIR, 8'h00);
        chk("trap/priv_pc", hz.priv_pc, 32'h8000_0040);
        chk("trap/epc", hz.epc, 32'h100);
        chk("trap/badaddr", hz.badaddr, 32'hBAD0);
        cycle("post_trap", RUN, 8'h00);

        // mispredict loses to a same-cycle store fault, and is ignored in drain
        hz.mispredict = 1; hz.fault_st = 1; hz.epc_m = 32'h444; hz.badaddr_m = 32'h555;
        hz.priv_target = 32'h600;
        cycle("misp_fault", TRAP0, 8'h00);
        hz.fault_st = 0;
        cycle("misp_in_drain", DRI, 8'h00);
        hz.mispredict = 0;
        cycle("misp_redirect", REDIR, 8'h00);
        chk("misp/epc", hz.epc, 32'h444);
        chk("misp/badaddr", hz.badaddr, 32'h555);
        chk("misp/priv_pc", hz.priv_pc, 32'h600);

        // mret: redirect without touching epc/badaddr
        hz.ret = 1; hz.epc_m = 32'h999; hz.badaddr_m = 32'h777; hz.priv_target = 32'h700;
        cycle("ret_entry", TRAP0, 8'h00);
        hz.ret = 0;
        cycle("ret_drain", DRI, 8'h00);
        cycle("ret_redirect", REDIR, 8'h00);
        chk("ret/epc", hz.epc, 32'h444);
        chk("ret/badaddr", hz.badaddr, 32'h555);
        chk("ret/priv_pc", hz.priv_pc, 32'h700);

        // drain timeout with m_busy stuck high
        idle_in();
        hz.fault_insn = 1; hz.epc_m = 32'h200; hz.m_busy = 1; hz.priv_target = 32'h300;
        cycle("to_entry", TRAP0, 8'h00);
        hz.fault_insn = 0;
        for (int i = 0; i < 15; i++) cycle("to_drain", DRB, 8'h00);
        cycle("to_redirect", REDIR, 8'h00);
        chk("to/priv_pc", hz.priv_pc, 32'h300);
        chk("to/epc", hz.epc, 32'h200);
        hz.m_busy = 0;
        cycle("to_idle", RUN, 8'h00);

        // reset in the middle of a drain
        hz.illegal_insn = 1; hz.epc_m = 32'h888; hz.m_busy = 1; hz.priv_target = 32'hDEAD0;
        cycle("rd_entry", TRAP0, 8'h00);
        hz.illegal_insn = 0;
        cycle("rd_drain1", DRB, 8'h00);
        cycle("rd_drain2", DRB, 8'h00);
        rst = 1'b1;
        cycle("rd_in_reset", 12'h000, 8'h00);
        rst = 1'b0;
        idle_in();
        cycle("rd_after", RUN, 8'h00);
        chk("rd/priv_pc", hz.priv_pc, 32'h0);
        chk("rd/epc", hz.epc, 32'h0);
        cycle("rd_no_redirect", RUN, 8'h00);

        // sticky halt
        hz.halt = 1;
        cycle("halt", HALTD, 8'h00);
        hz.halt = 0; hz.mispredict = 1; hz.fault_insn = 1;
        cycle("halted_ignores", HALTD, 8'h00);
        idle_in(); hz.f_busy = 1;
        cycle("halted_sticky", HALTD, 8'h00);
        idle_in();
        rst = 1'b1;
        cycle("halt_reset", 12'h000, 8'h00);
        rst = 1'b0;
        cycle("halt_released", RUN, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
